multicycle_vector_datapath: RTL
===============================

MULTICYCLE_VECTOR_DATAPATH -- requirements
Module: multicycle_vector_datapath

Interface
REQ-001 SHALL have parameter LANES, default 16, number of SIMD lanes.
REQ-002 SHALL have parameter LANE_W, default 8, bits per lane; vector width VW = LANES*LANE_W.
REQ-003 SHALL have parameter PC_W, default 18, program counter and instruction width.
REQ-004 SHALL have parameter ADDR_W, default 16, data-memory address width.
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 SHALL have port imem_addr, output, PC_W, instruction fetch address (equals pc).
REQ-008 SHALL have port imem_instr, input, PC_W, instruction word, combinationally valid for imem_addr.
REQ-009 SHALL have ports dmem_req, output, 1, and dmem_we, output, 1: data request and write enable.
REQ-010 SHALL have ports dmem_addr, output, ADDR_W, and dmem_wdata, output, VW.
REQ-011 SHALL have ports dmem_rdata, input, VW, and dmem_ack, input, 1, request completion.
REQ-012 SHALL have ports pc, output, PC_W; retire, output, 1, one-cycle pulse per completed instruction; halted, output, 1; illegal, output, 1.

Function
REQ-013 SHALL decode instruction fields as: opcode [17:12], rd [11:8], rs1 [7:4], rs2 [3:0], imm8 [7:0].
REQ-014 SHALL hold 16 VW-bit registers; R0 reads zero and writes to R0 are discarded.
REQ-015 SHALL use FSM states FETCH, DECODE, EXEC, MEM, WB, HALT; order FETCH->DECODE->EXEC->(MEM if VLD/VST)->WB->FETCH.
REQ-016 SHALL in FETCH latch imem_instr into IR; in DECODE latch rs1/rs2 register values into operand registers A/B.
REQ-017 SHALL implement VADD (0x01): rd = A + B lane-wise, each lane modulo 2^LANE_W, no carry between lanes.
REQ-018 SHALL implement VSUB (0x02): rd = A - B lane-wise, modulo 2^LANE_W.
REQ-019 SHALL implement VLD (0x03): dmem_addr = A[ADDR_W-1:0], dmem_we=0; WB writes dmem_rdata to rd.
REQ-020 SHALL implement VST (0x04): dmem_addr = A[ADDR_W-1:0], dmem_wdata = B, dmem_we=1; no register write.
REQ-021 SHALL implement JAL (0x05): rd = zero-extended (pc+4); next pc = pc+4 + (sign-extended imm8 << 2).
REQ-022 SHALL implement NOP (0x00) as no state change except pc advance, and HALT (0x3F) as entry to HALT.
REQ-023 SHALL treat any other opcode as illegal: enter HALT, set illegal=1, no register or memory write, no retire.
REQ-024 SHALL assert dmem_req in every MEM cycle, holding addr/we/wdata stable until the cycle dmem_ack=1 is sampled; the wait is unbounded.
REQ-025 SHALL ignore dmem_ack outside MEM.
REQ-026 SHALL for non-JAL instructions update pc = pc+4 in WB; all pc arithmetic wraps modulo 2^PC_W.
REQ-027 SHALL pulse retire for exactly one cycle in WB of each legal non-HALT instruction; HALT instruction retires on entry to HALT.
REQ-028 SHALL remain in HALT until reset; halted=1 in HALT; pc frozen.
REQ-029 SHALL give latency 4 cycles for ALU/JAL/NOP instructions and 4+N cycles for VLD/VST where N>=1 is the MEM cycles until ack.
REQ-030 SHALL read operands in DECODE so rd==rs1 or rd==rs2 uses pre-write values.

Reset
REQ-031 SHALL on reset set state=FETCH, pc=0, IR=0, A=B=0, all registers 0, dmem_req=0, dmem_we=0, retire=0, halted=0, illegal=0.
REQ-032 SHALL give reset priority over all events; reset during MEM deasserts dmem_req the cycle after reset is sampled and abandons the transaction.

Verification
REQ-033 SHALL cover: LANE_W=8, R1=all lanes 0xFF, R2=all lanes 0x01, VADD R3,R1,R2 -> R3 all lanes 0x00, no inter-lane carry, retire after 4 cycles.
REQ-034 SHALL cover: VLD R4,[R1] with dmem_ack delayed 3 cycles -> dmem_req high 3 MEM cycles with stable addr, R4=dmem_rdata, retire at cycle 7.
REQ-035 SHALL cover: JAL R5 imm8=0xFE at pc=0x10 -> R5=0x14, pc=0x0C; and pc=0x3FFFC plain NOP -> pc wraps to 0.
REQ-036 SHALL cover: VADD R0,R1,R2 then VSUB R6,R0,R0 -> R0 reads 0, R6=0.
REQ-037 SHALL cover: opcode 0x2A -> halted=1, illegal=1, no retire, no dmem_req; subsequent cycles pc unchanged.
REQ-038 SHALL cover: reset asserted during VST MEM wait -> dmem_req=0 next cycle, pc=0, state FETCH, no memory write on later ack.

Source files
------------

// File: rtl/multicycle_vector_datapath.sv
// Multicycle SIMD vector datapath: one instruction at a time through
// FETCH -> DECODE -> EXEC -> (MEM) -> WB, sixteen VW-bit vector registers.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   imem_addr/imem_instr  - instruction fetch address (= pc) and word
//   dmem_req/we/addr/wdata- data memory request, held until dmem_ack
//   dmem_rdata/dmem_ack   - load data and request completion
//   pc, retire, halted, illegal - architectural status
module multicycle_vector_datapath #(
    parameter int unsigned LANES  = 16,
    parameter int unsigned LANE_W = 8,
    parameter int unsigned PC_W   = 18,
    parameter int unsigned ADDR_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic [PC_W-1:0]         imem_addr,
    input  logic [PC_W-1:0]         imem_instr,
    output logic                    dmem_req,
    output logic                    dmem_we,
    output logic [ADDR_W-1:0]       dmem_addr,
    output logic [LANES*LANE_W-1:0] dmem_wdata,
    input  logic [LANES*LANE_W-1:0] dmem_rdata,
    input  logic                    dmem_ack,
    output logic [PC_W-1:0]         pc,
    output logic                    retire,
    output logic                    halted,
    output logic                    illegal
);

    localparam int unsigned VW    = LANES * LANE_W;
    localparam int unsigned NREGS = 16;

    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_VADD = 6'h01;
    localparam logic [5:0] OP_VSUB = 6'h02;
    localparam logic [5:0] OP_VLD  = 6'h03;
    localparam logic [5:0] OP_VST  = 6'h04;
    localparam logic [5:0] OP_JAL  = 6'h05;
    localparam logic [5:0] OP_HALT = 6'h3F;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    state_t          state;
    logic [PC_W-1:0] ir;
    logic [VW-1:0]   a_q;
    logic [VW-1:0]   b_q;
    logic [VW-1:0]   res_q;
    logic [PC_W-1:0] npc_q;
    logic            wen_q;
    logic [VW-1:0]   regs [NREGS];

    logic [5:0]      opcode;
    logic [3:0]      rd_idx;
    logic [3:0]      rs1_idx;
    logic [3:0]      rs2_idx;
    logic [VW-1:0]   rs1_val;
    logic [VW-1:0]   rs2_val;
    logic [VW-1:0]   vsum;
    logic [VW-1:0]   vdiff;
    logic [PC_W-1:0] pc_plus4;
    logic [PC_W-1:0] jal_off;

    assign opcode    = ir[17:12];
    assign rd_idx    = ir[11:8];
    assign rs1_idx   = ir[7:4];
    assign rs2_idx   = ir[3:0];
    assign imem_addr = pc;
    assign pc_plus4  = pc + PC_W'(4);
    // imm8 sign-extended and scaled to a word offset
    assign jal_off   = {{(PC_W-10){ir[7]}}, ir[7:0], 2'b00};

    // R0 is hard-wired to zero on the read side
    assign rs1_val = (rs1_idx == 4'd0) ? '0 : regs[rs1_idx];
    assign rs2_val = (rs2_idx == 4'd0) ? '0 : regs[rs2_idx];

    // Lane-wise add/sub; each lane wraps independently, no inter-lane carry
    always_comb begin
        vsum  = '0;
        vdiff = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            vsum[i*LANE_W +: LANE_W]  = a_q[i*LANE_W +: LANE_W] + b_q[i*LANE_W +: LANE_W];
            vdiff[i*LANE_W +: LANE_W] = a_q[i*LANE_W +: LANE_W] - b_q[i*LANE_W +: LANE_W];
        end
    end

    // Control FSM and all architectural state
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_FETCH;
            pc         <= '0;
            ir         <= '0;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            npc_q      <= '0;
            wen_q      <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            retire     <= 1'b0;
            halted     <= 1'b0;
            illegal    <= 1'b0;
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else begin
            retire <= 1'b0;
            case (state)
                ST_FETCH: begin
                    ir    <= imem_instr;
                    state <= ST_DECODE;
                end
                ST_DECODE: begin
                    a_q   <= rs1_val;
                    b_q   <= rs2_val;
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    npc_q <= pc_plus4;
                    wen_q <= 1'b0;
                    case (opcode)
                        OP_NOP: begin
                            state  <= ST_WB;
                            retire <= 1'b1;
                        end
                        OP_VADD: begin
                            res_q  <= vsum;
                            wen_q  <= 1'b1;
                            state  <= ST_WB;
                            retire <= 1'b1;
                        end
                        OP_VSUB: begin
                            res_q  <= vdiff;
                            wen_q  <= 1'b1;
                            state  <= ST_WB;
                            retire <= 1'b1;
                        end
                        OP_VLD: begin
                            dmem_req  <= 1'b1;
                            dmem_we   <= 1'b0;
                            dmem_addr <= a_q[ADDR_W-1:0];
                            wen_q     <= 1'b1;
                            state     <= ST_MEM;
                        end
                        OP_VST: begin
                            dmem_req   <= 1'b1;
                            dmem_we    <= 1'b1;
                            dmem_addr  <= a_q[ADDR_W-1:0];
                            dmem_wdata <= b_q;
                            state      <= ST_MEM;
                        end
                        OP_JAL: begin
                            res_q  <= {{(VW-PC_W){1'b0}}, pc_plus4};
                            wen_q  <= 1'b1;
                            npc_q  <= pc_plus4 + jal_off;
                            state  <= ST_WB;
                            retire <= 1'b1;
                        end
                        OP_HALT: begin
                            halted <= 1'b1;
                            retire <= 1'b1;
                            state  <= ST_HALT;
                        end
                        default: begin
                            halted  <= 1'b1;
                            illegal <= 1'b1;
                            state   <= ST_HALT;
                        end
                    endcase
                end
                ST_MEM: begin
                    // Request stays up, unchanged, until ack; load data captured here
                    if (dmem_ack) begin
                        res_q    <= dmem_rdata;
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        retire   <= 1'b1;
                        state    <= ST_WB;
                    end
                end
                ST_WB: begin
                    if (wen_q && (rd_idx != 4'd0)) begin
                        regs[rd_idx] <= res_q;
                    end
                    pc    <= npc_q;
                    state <= ST_FETCH;
                end
                ST_HALT: begin
                    state <= ST_HALT;
                end
                default: begin
                    state <= ST_FETCH;
                end
            endcase
        end
    end

endmodule
